// File: rtl/spi_rx_engine_if.sv
`timescale 1ns/1ps
// spi_rx_engine_if: pin- and controller-side bundle for the SPI receive engine.
//   SCLK/SS_N/MISO      : raw SPI pins (asynchronous to the system clock)
//   CPOL/CPHA/LSB_FIRST : frame mode, sampled when SS_N falls
//   RE                  : receive enable
//   READ                : pop request from the controller
//   DATA                : head-of-FIFO word
//   EMPTY_STATE/FULL_STATE/OVERRUN/BUSY : status
// slave  = engine side, master = controller/pin driver side.
interface spi_rx_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  SCLK;
  logic                  SS_N;
  logic                  MISO;
  logic                  CPOL;
  logic                  CPHA;
  logic                  LSB_FIRST;
  logic                  RE;
  logic                  READ;
  logic [DATA_WIDTH-1:0] DATA;
  logic                  EMPTY_STATE;
  logic                  FULL_STATE;
  logic                  OVERRUN;
  logic                  BUSY;

  modport slave (
    input  SCLK, SS_N, MISO, CPOL, CPHA, LSB_FIRST, RE, READ,
    output DATA, EMPTY_STATE, FULL_STATE, OVERRUN, BUSY
  );

  modport master (
    output SCLK, SS_N, MISO, CPOL, CPHA, LSB_FIRST, RE, READ,
    input  DATA, EMPTY_STATE, FULL_STATE, OVERRUN, BUSY
  );
endinterface

// File: rtl/spi_rx_engine.sv
`timescale 1ns/1ps
// spi_rx_engine: oversampled SPI receiver, all four modes, MSB/LSB-first,
// DATA_WIDTH-bit words queued in a FIFO_DEPTH-entry first-word-fall-through
// buffer.
//   i_clk : system clock (rising edge)
//   i_clr : synchronous active-high clear, wins over every other event
//   bus   : spi_rx_engine_if.slave (pins, mode, RE/READ, DATA and status)
module spi_rx_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_clr,
  spi_rx_engine_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  // ---------------- synchronisers + edge detect ----------------
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_miso_sync;
  logic                   r_sclk_d, r_ss_d;
  logic                   w_sclk, w_ss_n, w_miso;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_n = r_ss_sync[SYNC_STAGES-1];
  assign w_miso = r_miso_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sclk_sync <= '1;
      r_ss_sync   <= '1;
      r_miso_sync <= '0;
      r_sclk_d    <= 1'b1;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   bus.SS_N};
      r_miso_sync <= {r_miso_sync[SYNC_STAGES-2:0], bus.MISO};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss_n;
    end
  end

  // ---------------- mode register ----------------
  // Latched only on the synchronised SS_N falling edge so that mode pins
  // may move freely during a frame without corrupting it.
  logic r_cpol, r_cpha, r_lsb;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_lsb  <= 1'b0;
    end else if (r_ss_d && !w_ss_n) begin
      r_cpol <= bus.CPOL;
      r_cpha <= bus.CPHA;
      r_lsb  <= bus.LSB_FIRST;
    end
  end

  // ---------------- shift register / bit counter ----------------
  logic                  w_rise, w_fall, w_sample, w_shift_en, w_word_done;
  logic [DATA_WIDTH-1:0] r_sr, w_sr_next;
  logic [CW-1:0]         r_cnt;

  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_sclk & r_sclk_d;
  // CPOL==CPHA samples on rising SCLK (modes 0/3), otherwise falling.
  assign w_sample    = (r_cpol == r_cpha) ? w_rise : w_fall;
  assign w_shift_en  = w_sample & ~w_ss_n & bus.RE;
  assign w_sr_next   = r_lsb ? {w_miso, r_sr[DATA_WIDTH-1:1]}
                             : {r_sr[DATA_WIDTH-2:0], w_miso};
  assign w_word_done = w_shift_en && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_ss_n) begin
      // Deselect drops any partial word.
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_shift_en) begin
      r_sr  <= w_sr_next;
      r_cnt <= w_word_done ? '0 : r_cnt + CNT_ONE;
    end
  end

  // ---------------- receive FIFO ----------------
  // Pointers carry one extra wrap bit: equal => empty, only MSB differs => full.
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr, r_rptr;
  logic                  r_overrun;
  logic                  w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = bus.READ & ~w_empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push lands safely there.
  assign w_push  = w_word_done & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= w_sr_next;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (w_word_done && w_full && !bus.READ) r_overrun <= 1'b1;
    end
  end

  // All outputs derive from registers only.
  assign bus.DATA        = r_mem[r_rptr[AW-1:0]];
  assign bus.EMPTY_STATE = w_empty;
  assign bus.FULL_STATE  = w_full;
  assign bus.OVERRUN     = r_overrun;
  assign bus.BUSY        = (r_cnt != '0);
endmodule

// File: doc/spi_rx_engine.md
# spi_rx_engine

Parametrised SPI receive engine; successor to the 8-bit shift-register receiver. Oversamples an external SCLK/SS_N/MISO bus on the system clock, supports all four SPI modes and MSB/LSB-first order, and assembles DATA_WIDTH-bit words. Words are queued in a FIFO_DEPTH-entry buffer that the controller drains with READ. Sits between the SPI pins and the SPI controller, replacing the single-word receiver.

## Interface
- DATA_WIDTH, 8, bits per received word (2..32)
- FIFO_DEPTH, 4, words of receive buffering (power of 2, ≥2)
- SYNC_STAGES, 2, synchroniser flops on SCLK, SS_N, MISO (≥2)

- CLK  in  1  system clock; all logic on its rising edge
- CLR  in  1  synchronous, active-high reset
- SCLK  in  1  SPI serial clock (asynchronous to CLK)
- SS_N  in  1  slave select, active-low (asynchronous)
- MISO  in  1  serial data in (asynchronous)
- CPOL  in  1  clock polarity (quasi-static)
- CPHA  in  1  clock phase (quasi-static)
- LSB_FIRST  in  1  1 = first bit lands in DATA[0]; 0 = first bit lands in DATA[DATA_WIDTH-1]
- RE  in  1  receive enable; 0 = sample edges ignored
- READ  in  1  pop head word when not empty
- DATA  out  DATA_WIDTH  head-of-FIFO word (first-word fall-through)
- EMPTY_STATE  out  1  FIFO holds no words
- FULL_STATE  out  1  FIFO holds FIFO_DEPTH words
- OVERRUN  out  1  sticky; a completed word was dropped
- BUSY  out  1  partial word in progress (bit counter ≠ 0)

## Operation
- SCLK, SS_N, MISO each pass through SYNC_STAGES flops; one extra flop on SCLK gives edge detection.
- CPOL, CPHA, LSB_FIRST registered into a mode register on the CLK cycle in which synchronised SS_N goes 1→0; held for the whole frame. Changes while SS_N low have no effect.
- Sample edge: synchronised SCLK rising when CPOL==CPHA, falling otherwise. Other edge ignored (no transmit path in this block).
- On a sample edge with SS_N low and RE=1: MISO shifted into the shift register (left if MSB-first, right if LSB-first); bit counter increments.
- Counter reaching DATA_WIDTH: completed word pushed into FIFO, counter returns to 0 in the same cycle; subsequent edges start the next word (back-to-back frames under one SS_N allowed).
- Push while FULL_STATE=1 and READ=0: word dropped, FIFO unchanged, OVERRUN set. Push while full and READ=1: pop and push both succeed, occupancy unchanged.
- READ=1 with EMPTY_STATE=1: ignored, no pointer movement, no flag change.
- SS_N rising mid-word: partial word discarded, counter cleared, BUSY falls; nothing pushed.
- RE=0 mid-word: edges ignored, partial word and counter retained; resume on RE=1.
- OVERRUN cleared only by CLR.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty from MSB compare; wrap-around is modular.
- CLR: FIFO pointers, counter, shift register, mode register (CPOL=0, CPHA=0, LSB_FIRST=0), sync flops (SCLK and SS_N flops to 1, MISO to 0) and OVERRUN all reset; CLR overrides every simultaneous event, including a push on the same cycle.

## Timing
- Reset values: DATA = 0, EMPTY_STATE = 1, FULL_STATE = 0, OVERRUN = 0, BUSY = 0.
- Pin edge to internal sample: SYNC_STAGES+1 CLK cycles.
- Push on cycle N (last sample edge detected): EMPTY_STATE low and DATA valid from cycle N+1.
- READ sampled on cycle N: next word (or EMPTY_STATE=1) presented on cycle N+1.
- SCLK high and low phases each ≥ SYNC_STAGES+2 CLK periods; SS_N setup to first SCLK edge ≥ SYNC_STAGES+2 CLK periods. Violations are outside contract.
- No combinational path from any input to any output.

## Test plan
- Mode 0, MSB-first, DATA_WIDTH=8: shift 0xA5 under SS_N low -> DATA=0xA5, EMPTY_STATE=0 SYNC_STAGES+2 cycles after the 8th rising SCLK; READ -> EMPTY_STATE=1.
- Modes 1/2/3 plus LSB_FIRST=1: shift bit sequence 1,0,1,1,0,0,1,0 -> mode 3 MSB-first yields 0xB2; mode 1 LSB-first yields 0x4D.
- Fill: 5 back-to-back words 0x01..0x05 under one SS_N, no READ, FIFO_DEPTH=4 -> FULL_STATE=1 after 4th, OVERRUN=1 after 5th; reads return 0x01..0x04, then EMPTY_STATE=1.
- Abort: SS_N high after 5 bits, then full word 0x3C -> only 0x3C queued, BUSY=0 between frames.
- Full push+pop same cycle: FIFO full, READ asserted on push cycle -> FULL_STATE stays 1, OVERRUN stays 0, order preserved.
- CLR mid-frame with 2 words queued -> all outputs at reset values next cycle; the next frame decodes correctly.
